panel_cmd_rx: RTL and testbench
===============================

// Module: panel_cmd_rx
// PURPOSE
//  Decodes the serial control-panel command stream (bytes from the UART RX side) into
//  panel switch state: 12 function keys, rotary switch position and 16 data keys (kl).
//  Sits between the UART receiver and the P-K control panel logic; also requests an
//  LED/indicator refresh from the panel output stage after every accepted change.
// PARAMETERS
//  SYNC_STAGES     2        rx_ready synchronizer depth (rx_ready comes from clk_uart domain)
//  TIMEOUT_CYCLES  1000000  clk_sys cycles allowed between bytes of a multi-byte frame
// PORTS
//  clk_sys     in   1     system clock
//  rst         in   1     reset, synchronous, active-high
//  rx_byte     in   8     received byte; stable while rx_ready high and until next frame
//  rx_ready    in   1     byte-valid level from UART (async to clk_sys)
//  fnkey       out  12    function key levels, index = FN code (0 START .. 11 CLEAR)
//  rotary_pos  out  [0:3] rotary switch position
//  kl          out  [0:15] data keys, kl[0] = MSB
//  send_leds   out  1     one-cycle request for panel LED frame transmission
//  frame_err   out  1     one-cycle pulse: keys frame abandoned on timeout
// BEHAVIOUR
//  Reset: fnkey=0, rotary_pos=0, kl=0, send_leds=0, frame_err=0, state=IDLE, timer=0.
//  Input: rx_ready through SYNC_STAGES flops, then rising-edge detect -> 1-cycle strobe.
//   rx_byte is sampled on the strobe cycle. Latency rx_ready rise -> output update:
//   SYNC_STAGES+2 clk_sys edges (4 at default). rx_ready held high yields one strobe.
//  Command byte (state IDLE), decoded on byte[7:6]:
//   2'b10 FN:    fnkey[byte[3:0]] <= byte[5]; index 12..15 ignored (no send_leds).
//   2'b11 ROT:   rotary_pos <= byte[3:0].
//   2'b01 KEYS:  go to KEY_HI; byte[5:0] don't-care.
//   2'b00 REQ:   byte==8'h00 -> send_leds pulse only; any other 2'b00 byte ignored.
//  FSM: IDLE -(KEYS)-> KEY_HI -(byte: hold hi=byte)-> KEY_LO -(byte)-> IDLE with
//   kl <= {hi, byte} written atomically in one cycle; kl never shows half an update.
//   In KEY_HI/KEY_LO every byte is data (no command decode), including 8'h00/8'hFF.
//  Timeout: counter cleared on entering KEY_HI and on each accepted data byte,
//   increments each cycle in KEY_HI/KEY_LO; reaching TIMEOUT_CYCLES -> IDLE, kl
//   unchanged, frame_err pulses 1 cycle. Strobe in same cycle as expiry: byte wins,
//   accepted as data, no frame_err.
//  send_leds: pulses 1 cycle, registered, in the cycle after any applied FN, ROT,
//   completed KEYS frame or REQ; pulses even if the value written equals the old one.
//   Never asserted on ignored bytes, on timeout, or on the first data byte.
//  Outputs are registers; no combinational path from rx_byte/rx_ready to outputs.
//  rst mid-frame: FSM to IDLE, all outputs to reset values, partial hi byte discarded.
//  Strobes arrive at most once per UART byte time; back-to-back strobes one cycle
//   apart must still each be processed (no byte dropped).
// TESTING
//  1 Reset then send 8'hA0 (FN0 set) -> fnkey=12'h001 after 4 clks, send_leds 1 pulse;
//    then 8'h80 -> fnkey=0, second send_leds pulse.
//  2 Send 8'hC9 -> rotary_pos=4'h9; send 8'hAC (FN index 12) -> fnkey and send_leds
//    unchanged.
//  3 Send 8'h40,8'h12,8'h34 -> kl=16'h1234 only after third byte, send_leds once;
//    kl stays at old value between bytes 2 and 3.
//  4 Send 8'h40,8'h00 (data, not REQ), wait TIMEOUT_CYCLES -> frame_err pulse, kl
//    unchanged, state IDLE; next 8'hC3 -> rotary_pos=3 (decoded as command).
//  5 Send 8'h00 -> only send_leds pulses; 8'h3F -> nothing; rx_ready held high for
//    100 clks -> exactly one strobe/one update.
//  6 Assert rst after 8'h40,8'hAB -> all outputs 0; then 8'hCD -> rotary_pos=4'hD
//    (no stale KEY_LO state); byte strobed on timeout cycle -> accepted, no frame_err.

Source files
------------

// File: rtl/panel_cmd_rx.sv
// Serial control-panel command decoder: UART bytes -> function keys, rotary
// position and 16-bit data keys, with an LED refresh request after every change.
module panel_cmd_rx #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic [7:0]  rx_byte,
  input  logic        rx_ready,
  output logic [11:0] fnkey,
  output logic [0:3]  rotary_pos,
  output logic [0:15] kl,
  output logic        send_leds,
  output logic        frame_err
);

  localparam int unsigned   TW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, KEY_HI, KEY_LO} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ready_prev_q;
  logic                   strobe_q;
  logic [7:0]             hi_q, hi_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [11:0]            fnkey_d;
  logic [0:3]             rot_d;
  logic [0:15]            kl_d;
  logic                   leds_d, err_d;
  logic                   expire;

  // Strobe is registered so rx_ready rise -> output update is SYNC_STAGES+2 edges.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      sync_q       <= '0;
      ready_prev_q <= 1'b0;
      strobe_q     <= 1'b0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], rx_ready};
      ready_prev_q <= sync_q[SYNC_STAGES-1];
      strobe_q     <= sync_q[SYNC_STAGES-1] & ~ready_prev_q;
    end
  end

  // A byte arriving on the expiry cycle takes precedence over the timeout.
  assign expire = (state_q != IDLE) && !strobe_q && (timer_q == T_LAST);

  always_ff @(posedge clk_sys) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (strobe_q && rx_byte[7:6] == 2'b01) state_d = KEY_HI;
      KEY_HI:  if (strobe_q) state_d = KEY_LO;
               else if (expire) state_d = IDLE;
      KEY_LO:  if (strobe_q || expire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fnkey_d = fnkey;
    rot_d   = rotary_pos;
    kl_d    = kl;
    hi_d    = hi_q;
    timer_d = '0;
    leds_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (strobe_q) begin
          case (rx_byte[7:6])
            2'b10: begin
              if (rx_byte[3:0] < 4'd12) begin
                fnkey_d[rx_byte[3:0]] = rx_byte[5];
                leds_d                = 1'b1;
              end
            end
            2'b11: begin
              rot_d  = rx_byte[3:0];
              leds_d = 1'b1;
            end
            2'b00:   leds_d = (rx_byte == 8'h00);
            default: ;
          endcase
        end
      end
      KEY_HI: begin
        if (strobe_q)    hi_d    = rx_byte;
        else if (expire) err_d   = 1'b1;
        else             timer_d = timer_q + 1'b1;
      end
      KEY_LO: begin
        if (strobe_q) begin
          kl_d   = {hi_q, rx_byte};
          leds_d = 1'b1;
        end else if (expire) begin
          err_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      fnkey      <= '0;
      rotary_pos <= '0;
      kl         <= '0;
      hi_q       <= '0;
      timer_q    <= '0;
      send_leds  <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      fnkey      <= fnkey_d;
      rotary_pos <= rot_d;
      kl         <= kl_d;
      hi_q       <= hi_d;
      timer_q    <= timer_d;
      send_leds  <= leds_d;
      frame_err  <= err_d;
    end
  end

endmodule

// File: tb/tb_panel_cmd_rx.sv
// Bench for panel_cmd_rx: directed scenarios plus random byte streams checked
// against a frame-level reference model of the command protocol.
module tb_panel_cmd_rx;

  localparam int unsigned TMO = 40;

  logic        clk_sys = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_byte = '0;
  logic        rx_ready = 1'b0;
  logic [11:0] fnkey;
  logic [0:3]  rotary_pos;
  logic [0:15] kl;
  logic        send_leds, frame_err;

  panel_cmd_rx #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_sys    (clk_sys),
    .rst        (rst),
    .rx_byte    (rx_byte),
    .rx_ready   (rx_ready),
    .fnkey      (fnkey),
    .rotary_pos (rotary_pos),
    .kl         (kl),
    .send_leds  (send_leds),
    .frame_err  (frame_err)
  );

  always #5 clk_sys = ~clk_sys;

  int unsigned cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  // Reference model: protocol state as "data bytes still owed to a KEYS frame".
  logic [11:0] m_fn;
  logic [3:0]  m_rot;
  logic [15:0] m_kl;
  logic [7:0]  m_hi;
  int          m_need;

  task automatic model_reset();
    m_fn = '0; m_rot = '0; m_kl = '0; m_hi = '0; m_need = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, output logic leds);
    leds = 1'b0;
    if (m_need == 2) begin
      m_hi = b; m_need = 1;
    end else if (m_need == 1) begin
      m_kl = {m_hi, b}; m_need = 0; leds = 1'b1;
    end else begin
      case (b[7:6])
        2'b10: if (int'(b[3:0]) < 12) begin m_fn[b[3:0]] = b[5]; leds = 1'b1; end
        2'b11: begin m_rot = b[3:0]; leds = 1'b1; end
        2'b01: m_need = 2;
        default: leds = (b == 8'h00);
      endcase
    end
  endtask

  function automatic logic [31:0] dut_view();
    return {fnkey, rotary_pos, kl};
  endfunction

  function automatic logic [31:0] model_view();
    return {m_fn, m_rot, m_kl};
  endfunction

  // Drive one byte from a negedge; record outputs after edge 3 and edge 4.
  task automatic drive_byte(input logic [7:0] b, input int hold,
                            output logic [31:0] at3, output logic [31:0] at4,
                            output int leds_n, output int err_n,
                            output logic leds4, output int unsigned upd);
    rx_byte = b; rx_ready = 1'b1;
    leds_n = 0; err_n = 0; at3 = '0; at4 = '0; leds4 = 1'b0; upd = 0;
    for (int i = 1; i <= hold; i++) begin
      @(negedge clk_sys);
      if (send_leds) leds_n++;
      if (frame_err) err_n++;
      if (i == 3) at3 = dut_view();
      if (i == 4) begin at4 = dut_view(); leds4 = send_leds; upd = cyc; end
    end
    rx_ready = 1'b0;
    repeat (3) @(negedge clk_sys);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk_sys);
    model_reset();
    checks++;
    if (dut_view() !== 32'h0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=%h", dut_view(), 32'h0);
    end
    checks++;
    if ({send_leds, frame_err} !== 2'b00) begin
      failures++; $display("FAIL reset_pulses got=%b exp=00", {send_leds, frame_err});
    end
    rst = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic test_fn_rot();
    logic [7:0] seq [4];
    logic [31:0] a3, a4, old_v, new_v;
    int ln, en;
    logic l4, exp_l;
    int unsigned up;
    seq = '{8'hA0, 8'h80, 8'hC9, 8'hAC};
    foreach (seq[i]) begin
      old_v = model_view();
      model_byte(seq[i], exp_l);
      new_v = model_view();
      drive_byte(seq[i], 8, a3, a4, ln, en, l4, up);
      checks++;
      if ({a3, a4} !== {old_v, new_v}) begin
        failures++;
        $display("FAIL fn_rot_view byte=%h got=%h/%h exp=%h/%h", seq[i], a3, a4, old_v, new_v);
      end
      checks++;
      if (l4 !== exp_l || ln != int'(exp_l) || en != 0) begin
        failures++;
        $display("FAIL fn_rot_pulses byte=%h leds4=%b leds_n=%0d err_n=%0d exp leds=%b err=0",
                 seq[i], l4, ln, en, exp_l);
      end
    end
    checks++;
    if (rotary_pos !== 4'h9 || fnkey !== 12'h000) begin
      failures++; $display("FAIL fn_rot_final rot=%h fn=%h exp rot=9 fn=000", rotary_pos, fnkey);
    end
  endtask

  task automatic test_keys();
    logic [7:0] seq [3];
    logic [31:0] a3, a4, old_v, new_v;
    int ln, en;
    logic l4, exp_l;
    int unsigned up;
    seq = '{8'h40, 8'h12, 8'h34};
    foreach (seq[i]) begin
      old_v = model_view();
      model_byte(seq[i], exp_l);
      new_v = model_view();
      drive_byte(seq[i], 8, a3, a4, ln, en, l4, up);
      checks++;
      if ({a3, a4} !== {old_v, new_v}) begin
        failures++;
        $display("FAIL keys_view byte=%h got=%h/%h exp=%h/%h", seq[i], a3, a4, old_v, new_v);
      end
      checks++;
      if (l4 !== exp_l || ln != int'(exp_l) || en != 0) begin
        failures++;
        $display("FAIL keys_pulses byte=%h leds4=%b leds_n=%0d err_n=%0d exp leds=%b err=0",
                 seq[i], l4, ln, en, exp_l);
      end
    end
    checks++;
    if (kl !== 16'h1234) begin
      failures++; $display("FAIL keys_value got=%h exp=1234", kl);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] a3, a4;
    int ln, en, nerr, nleds;
    logic l4, exp_l;
    int unsigned up, err_cyc;
    logic [15:0] kl_before;
    kl_before = m_kl;
    model_byte(8'h40, exp_l);
    drive_byte(8'h40, 8, a3, a4, ln, en, l4, up);
    model_byte(8'h00, exp_l);
    drive_byte(8'h00, 8, a3, a4, ln, en, l4, up);
    checks++;
    if (ln != 0 || en != 0) begin
      failures++; $display("FAIL tmo_data00 leds_n=%0d err_n=%0d exp 0/0", ln, en);
    end
    nerr = 0; nleds = 0; err_cyc = 0;
    for (int i = 0; i < int'(TMO) + 20; i++) begin
      @(negedge clk_sys);
      if (send_leds) nleds++;
      if (frame_err) begin
        if (nerr == 0) err_cyc = cyc;
        nerr++;
      end
    end
    m_need = 0;
    checks++;
    if (nerr != 1 || nleds != 0) begin
      failures++; $display("FAIL tmo_pulse frame_err=%0d send_leds=%0d exp 1/0", nerr, nleds);
    end
    checks++;
    if (err_cyc - up != TMO) begin
      failures++; $display("FAIL tmo_latency got=%0d exp=%0d", err_cyc - up, TMO);
    end
    checks++;
    if (kl !== kl_before) begin
      failures++; $display("FAIL tmo_kl got=%h exp=%h", kl, kl_before);
    end
    model_byte(8'hC3, exp_l);
    drive_byte(8'hC3, 8, a3, a4, ln, en, l4, up);
    checks++;
    if (a4 !== model_view() || rotary_pos !== 4'h3 || ln != 1) begin
      failures++; $display("FAIL tmo_next_cmd got=%h rot=%h leds_n=%0d exp=%h rot=3 leds_n=1",
                           a4, rotary_pos, ln, model_view());
    end
  endtask

  task automatic test_expiry_race();
    logic [31:0] a3, a4;
    int ln, en;
    logic l4, exp_l;
    int unsigned up, guard;
    model_byte(8'h40, exp_l);
    drive_byte(8'h40, 8, a3, a4, ln, en, l4, up);
    model_byte(8'h5A, exp_l);
    drive_byte(8'h5A, 8, a3, a4, ln, en, l4, up);
    guard = 0;
    while (cyc < up + TMO - 4 && guard < 1000) begin
      @(negedge clk_sys);
      guard++;
    end
    checks++;
    if (cyc != up + TMO - 4) begin
      failures++; $display("FAIL race_align cyc=%0d exp=%0d", cyc, up + TMO - 4);
    end
    model_byte(8'hA5, exp_l);
    drive_byte(8'hA5, 10, a3, a4, ln, en, l4, up);
    checks++;
    if (kl !== 16'h5AA5 || ln != 1 || en != 0) begin
      failures++; $display("FAIL race_byte_wins kl=%h leds_n=%0d err_n=%0d exp kl=5aa5 1/0",
                           kl, ln, en);
    end
  endtask

  task automatic test_req_hold();
    logic [7:0] seq [3];
    int hold [3];
    logic [31:0] a3, a4, old_v, new_v;
    int ln, en;
    logic l4, exp_l;
    int unsigned up;
    seq = '{8'h00, 8'h3F, 8'hC5};
    hold = '{8, 8, 100};
    foreach (seq[i]) begin
      old_v = model_view();
      model_byte(seq[i], exp_l);
      new_v = model_view();
      drive_byte(seq[i], hold[i], a3, a4, ln, en, l4, up);
      checks++;
      if ({a3, a4, dut_view()} !== {old_v, new_v, new_v}) begin
        failures++;
        $display("FAIL req_view byte=%h got=%h/%h/%h exp=%h/%h", seq[i], a3, a4, dut_view(),
                 old_v, new_v);
      end
      checks++;
      if (l4 !== exp_l || ln != int'(exp_l) || en != 0) begin
        failures++;
        $display("FAIL req_pulses byte=%h hold=%0d leds4=%b leds_n=%0d err_n=%0d exp leds=%b",
                 seq[i], hold[i], l4, ln, en, exp_l);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [2];
    int reps [2];
    int nl, ne, exp_n;
    logic exp_l;
    bytes = '{8'h40, 8'hA3};
    reps  = '{3, 2};
    foreach (bytes[k]) begin
      exp_n = 0;
      for (int r = 0; r < reps[k]; r++) begin
        model_byte(bytes[k], exp_l);
        if (exp_l) exp_n++;
      end
      nl = 0; ne = 0;
      rx_byte = bytes[k];
      for (int r = 0; r < reps[k]; r++) begin
        rx_ready = 1'b1;
        @(negedge clk_sys);
        if (send_leds) nl++;
        if (frame_err) ne++;
        rx_ready = 1'b0;
        @(negedge clk_sys);
        if (send_leds) nl++;
        if (frame_err) ne++;
      end
      repeat (8) begin
        @(negedge clk_sys);
        if (send_leds) nl++;
        if (frame_err) ne++;
      end
      checks++;
      if (dut_view() !== model_view() || nl != exp_n || ne != 0) begin
        failures++;
        $display("FAIL b2b byte=%h got=%h leds=%0d err=%0d exp=%h leds=%0d err=0",
                 bytes[k], dut_view(), nl, ne, model_view(), exp_n);
      end
    end
  endtask

  task automatic test_rst_midframe();
    logic [31:0] a3, a4;
    int ln, en;
    logic l4, exp_l;
    int unsigned up;
    model_byte(8'h40, exp_l);
    drive_byte(8'h40, 8, a3, a4, ln, en, l4, up);
    model_byte(8'hAB, exp_l);
    drive_byte(8'hAB, 8, a3, a4, ln, en, l4, up);
    rst = 1'b1;
    repeat (2) @(negedge clk_sys);
    model_reset();
    checks++;
    if (dut_view() !== 32'h0 || send_leds !== 1'b0 || frame_err !== 1'b0) begin
      failures++; $display("FAIL midframe_rst got=%h leds=%b err=%b exp=0", dut_view(),
                           send_leds, frame_err);
    end
    rst = 1'b0;
    @(negedge clk_sys);
    model_byte(8'hCD, exp_l);
    drive_byte(8'hCD, 8, a3, a4, ln, en, l4, up);
    checks++;
    if (rotary_pos !== 4'hD || kl !== 16'h0 || ln != 1 || en != 0) begin
      failures++; $display("FAIL midframe_next rot=%h kl=%h leds_n=%0d err_n=%0d exp rot=d kl=0 1/0",
                           rotary_pos, kl, ln, en);
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic [31:0] a3, a4, old_v, new_v;
    int ln, en, nerr, exp_err;
    logic l4, exp_l;
    int unsigned up;
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        exp_err = (m_need != 0) ? 1 : 0;
        m_need = 0;
        nerr = 0;
        repeat (TMO + 10) begin
          @(negedge clk_sys);
          if (frame_err) nerr++;
        end
        checks++;
        if (nerr != exp_err || dut_view() !== model_view()) begin
          failures++; $display("FAIL rnd_idle n=%0d err=%0d view=%h exp err=%0d view=%h",
                               n, nerr, dut_view(), exp_err, model_view());
        end
      end else begin
        b = {2'($urandom_range(0, 3)), 6'($urandom)};
        if ($urandom_range(0, 7) == 0) b = 8'h00;
        old_v = model_view();
        model_byte(b, exp_l);
        new_v = model_view();
        drive_byte(b, 8, a3, a4, ln, en, l4, up);
        checks++;
        if ({a3, a4} !== {old_v, new_v} || l4 !== exp_l || ln != int'(exp_l) || en != 0) begin
          failures++;
          $display("FAIL rnd_byte n=%0d byte=%h got=%h/%h leds4=%b leds_n=%0d err_n=%0d exp=%h/%h leds=%b",
                   n, b, a3, a4, l4, ln, en, old_v, new_v, exp_l);
        end
      end
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    @(negedge clk_sys);
    test_reset();
    test_fn_rot();
    test_keys();
    test_timeout();
    test_expiry_race();
    test_req_hold();
    test_back_to_back();
    test_rst_midframe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
